nibble_serial_adder_ctrl: RTL and testbench
===========================================

Name: nibble_serial_adder_ctrl

Overview:
- Sequencing controller that performs a WIDTH-bit add using one SLICE-bit adder slice, reused over WIDTH/SLICE clock cycles (least-significant slice first).
- Carry is registered between slices.
- Trades latency for area against the parallel ripple adder in the lab adder set.
- Drop-in producer of s/c_out for datapaths that tolerate multi-cycle latency; start/busy/done handshake.

Parameters:
WIDTH, 16, operand/result width in bits; must be an integer multiple of SLICE
SLICE, 4, bits added per cycle by the internal slice adder

Ports:
clk  input  1  single clock, rising-edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; accepted only when busy=0
a  input  WIDTH  operand A, sampled on the accepting edge only
b  input  WIDTH  operand B, sampled on the accepting edge only
c_in  input  1  carry-in, sampled on the accepting edge only
busy  output  1  high while slices are being processed
done  output  1  one-cycle pulse: s/c_out just updated
s  output  WIDTH  sum result, registered, held between operations
c_out  output  1  carry-out of MSB slice, registered, held

Behaviour:
- Clock and reset (already decided): one clock, clk; reset rst is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, s=0, c_out=0, slice counter=0, carry reg=0, operand regs=0.
- Reset asserted mid-operation aborts the operation; no done pulse is produced for it.
- States:
  - IDLE: waiting for a request.
  - RUN: processing slices.
  - DONE: one cycle; done=1, busy=0.
- Transitions:
  - IDLE, start=1: latch a, b, c_in into operand regs; carry reg<=c_in; counter<=0; go to RUN.
  - RUN, every edge: slice k=counter adds a_reg[k*SLICE+:SLICE] + b_reg[k*SLICE+:SLICE] + carry reg. The slice sum goes into work reg slice k and the slice carry goes into carry reg. Counter increments.
  - RUN, after slice N-1 (N=WIDTH/SLICE): s<=completed work reg, c_out<=final carry; go to DONE.
  - DONE, start=1: accepted exactly as in IDLE (back-to-back, go to RUN).
  - DONE, start=0: go to IDLE.
- Latency: done is high in the cycle following edge E+N, where E is the accepting edge. Default N=4. Throughput is one operation per N+1 cycles.
- busy=1 exactly in RUN. start while busy=1 is ignored (not queued), and its a/b/c_in are not sampled.
- Operand changes on a/b/c_in after the accepting edge have no effect on the result.
- s and c_out change only on the RUN->DONE edge. Partial results are never visible on s.
- Arithmetic is unsigned modulo 2^WIDTH; c_out is the true carry of a+b+c_in.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled with the operands on the accepting edge.
  - sub=1: the slice uses ~b, the initial carry reg is forced to 1 and c_in is ignored, so the result is a-b modulo 2^WIDTH.
  - c_out=1 means no borrow (a>=b); c_out=0 means borrow.
  - sub=0: identical to the base behaviour.
- Undefined: no sub port; add-only.

Test Plan:
- Basic add, then zero operand: reset, pulse start with a=100, b=111, c_in=0 -> busy high for 4 cycles; done one cycle later with s=211, c_out=0. Next start with a=0, b=111 -> s=111, c_out=0.
- Full carry chain: start with a=0xFFFF, b=0x0001, c_in=0 -> s=0x0000, c_out=1. Start with a=0xFFFF, b=0xFFFF, c_in=1 -> s=0xFFFF, c_out=1.
- Ignore start while busy: start with a=0x1234, b=0x1111; 2 cycles later start with a=0xFFFF, b=0xFFFF while busy=1 -> single done, s=0x2345, c_out=0. Then change a/b mid-RUN -> result unaffected.
- Back-to-back requests: start held high across the done cycle with new a=0x00F0, b=0x0F0F -> RUN re-entered directly from DONE. Second done N+1 cycles after the first, s=0x0FFF.
- Reset mid-operation: assert rst during the 2nd RUN cycle -> busy, done, s and c_out go to 0 immediately (async). No done pulse follows; the next start operates normally.
- SERIAL_ADDER_SUB_EN build: sub=1, a=5, b=7 -> s=0xFFFE, c_out=0. Then sub=1, a=0x0100, b=0x0001 -> s=0x00FF, c_out=1.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Start/busy/done handshake and operand/result bus for nibble_serial_adder_ctrl.
// The sub signal exists only when SERIAL_ADDER_SUB_EN is defined.
interface nibble_serial_adder_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             c_out;

  modport master (
    output start, a, b, c_in,
`ifdef SERIAL_ADDER_SUB_EN
    output sub,
`endif
    input  busy, done, s, c_out
  );

  modport slave (
    input  start, a, b, c_in,
`ifdef SERIAL_ADDER_SUB_EN
    input  sub,
`endif
    output busy, done, s, c_out
  );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit adder built from one SLICE-bit slice reused over WIDTH/SLICE cycles, LSB slice first.
// Optional SERIAL_ADDER_SUB_EN adds a sub request bit that turns the operation into a-b.
module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input logic                    clk,
  input logic                    rst,
  nibble_serial_adder_ctrl_if.slave bus
);
  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] work_reg;
  logic [WIDTH-1:0] work_nxt;
  logic [WIDTH-1:0] s_reg;
  logic             carry_reg;
  logic             c_out_reg;
  logic             sub_reg;
  logic             sub_in;
  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic [SLICE:0]   sl_sum;
  logic             accept;
  logic             last;
  logic             busy;
  logic             done;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_in = bus.sub;
`else
  assign sub_in = 1'b0;
`endif

  // A request is only taken outside RUN; in DONE it restarts immediately.
  assign accept = bus.start && (state != RUN);
  assign last   = (cnt == CW'(N - 1));

  always_comb begin
    a_sl     = a_reg[cnt*SLICE +: SLICE];
    b_sl     = sub_reg ? ~b_reg[cnt*SLICE +: SLICE] : b_reg[cnt*SLICE +: SLICE];
    sl_sum   = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry_reg};
    work_nxt = work_reg;
    work_nxt[cnt*SLICE +: SLICE] = sl_sum[SLICE-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      work_reg  <= '0;
      s_reg     <= '0;
      carry_reg <= 1'b0;
      c_out_reg <= 1'b0;
      sub_reg   <= 1'b0;
      cnt       <= '0;
    end else if (accept) begin
      a_reg     <= bus.a;
      b_reg     <= bus.b;
      sub_reg   <= sub_in;
      carry_reg <= sub_in ? 1'b1 : bus.c_in;
      cnt       <= '0;
    end else if (state == RUN) begin
      work_reg  <= work_nxt;
      carry_reg <= sl_sum[SLICE];
      cnt       <= cnt + CW'(1);
      if (last) begin
        s_reg     <= work_nxt;
        c_out_reg <= sl_sum[SLICE];
      end
    end
  end

  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.s     = s_reg;
  assign bus.c_out = c_out_reg;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl: vector table, corner sequences, random ops.
module tb_nibble_serial_adder_ctrl;
  localparam int WIDTH = 16;
  localparam int SLICE = 4;
  localparam int N     = WIDTH / SLICE;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

  nibble_serial_adder_ctrl #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic [WIDTH-1:0] exp_s;
    logic             exp_c;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_sub(input logic v);
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub = v;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: full-width arithmetic straight from the operation definition.
  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                           input logic c_in, input logic sub);
    if (sub) return {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
    return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};
  endfunction

  // Accepts one op, scrambles inputs afterwards, checks latency, held s and the result.
  task automatic run_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic c_in, input logic sub,
                        input logic [WIDTH-1:0] exp_s, input logic exp_c);
    logic [WIDTH-1:0] s_prev;
    int busy_cnt;
    int edges;
    bit seen;
    s_prev    = bus.s;
    bus.a     = a;
    bus.b     = b;
    bus.c_in  = c_in;
    set_sub(sub);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.a     = WIDTH'($urandom);
    bus.b     = WIDTH'($urandom);
    bus.c_in  = 1'($urandom);
    set_sub(1'($urandom));
    busy_cnt = 0;
    edges    = 0;
    seen     = 0;
    while (!seen && edges < 4 * N + 8) begin
      if (bus.done) begin
        seen = 1;
      end else begin
        if (bus.busy) busy_cnt++;
        if (bus.s !== s_prev) begin
          check({name, " s_held"}, 32'(bus.s), 32'(s_prev));
          s_prev = bus.s;
        end
        tick();
        edges++;
      end
    end
    check({name, " done_seen"}, 32'(seen), 32'd1);
    check({name, " latency"}, 32'(edges), 32'(N));
    check({name, " busy_cycles"}, 32'(busy_cnt), 32'(N));
    check({name, " busy_in_done"}, 32'(bus.busy), 32'd0);
    check({name, " s"}, 32'(bus.s), 32'(exp_s));
    check({name, " c_out"}, 32'(bus.c_out), 32'(exp_c));
  endtask

  initial begin
    logic [WIDTH:0] r;
    logic [WIDTH-1:0] ra, rb;
    logic rc, rs;
    int cnt;
    bit seen;

    vecs.push_back('{16'd100,  16'd111,  1'b0, 1'b0, 16'd211,  1'b0});
    vecs.push_back('{16'd0,    16'd111,  1'b0, 1'b0, 16'd111,  1'b0});
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1});
    vecs.push_back('{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0});
    vecs.push_back('{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0});
`ifdef SERIAL_ADDER_SUB_EN
    vecs.push_back('{16'd5,    16'd7,    1'b0, 1'b1, 16'hFFFE, 1'b0});
    vecs.push_back('{16'h0100, 16'h0001, 1'b1, 1'b1, 16'h00FF, 1'b1});
`endif

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.c_in  = 1'b0;
    set_sub(1'b0);
    rst = 1'b1;
    tick();
    tick();
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset s", 32'(bus.s), 32'd0);
    check("reset c_out", 32'(bus.c_out), 32'd0);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].c_in, vecs[i].sub,
             vecs[i].exp_s, vecs[i].exp_c);
      tick();
    end

    // start while busy is ignored and not queued
    bus.a = 16'h1234; bus.b = 16'h1111; bus.c_in = 1'b0; set_sub(1'b0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.c_in = 1'b1; bus.start = 1'b1;
    check("ignore busy_at_start", 32'(bus.busy), 32'd1);
    tick();
    bus.start = 1'b0;
    bus.a = 16'hAAAA; bus.b = 16'h5555;
    cnt = 0; seen = 0;
    while (!seen && cnt < 20) begin
      if (bus.done) seen = 1; else begin tick(); cnt++; end
    end
    check("ignore done_seen", 32'(seen), 32'd1);
    check("ignore s", 32'(bus.s), 32'h2345);
    check("ignore c_out", 32'(bus.c_out), 32'd0);
    cnt = 0;
    for (int i = 0; i < 2 * N; i++) begin
      tick();
      if (bus.done || bus.busy) cnt++;
    end
    check("ignore no_second_op", 32'(cnt), 32'd0);

    // back-to-back: start held across the done cycle
    bus.a = 16'h0001; bus.b = 16'h0002; bus.c_in = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cnt = 0;
    while (!bus.done && cnt < 20) begin tick(); cnt++; end
    check("b2b first_s", 32'(bus.s), 32'h0003);
    bus.a = 16'h00F0; bus.b = 16'h0F0F; bus.c_in = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("b2b rerun_busy", 32'(bus.busy), 32'd1);
    cnt = 1;
    while (!bus.done && cnt < 20) begin tick(); cnt++; end
    check("b2b spacing", 32'(cnt), 32'(N + 1));
    check("b2b s", 32'(bus.s), 32'h0FFF);
    check("b2b c_out", 32'(bus.c_out), 32'd0);
    tick();

    // reset during the second RUN cycle
    bus.a = 16'h4321; bus.b = 16'h1111; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst done", 32'(bus.done), 32'd0);
    check("rst s", 32'(bus.s), 32'd0);
    check("rst c_out", 32'(bus.c_out), 32'd0);
    tick();
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 2 * N; i++) begin
      tick();
      if (bus.done || bus.busy) cnt++;
    end
    check("rst no_done", 32'(cnt), 32'd0);
    run_op("post_rst", 16'h4321, 16'h1111, 1'b0, 1'b0, 16'h5432, 1'b0);
    tick();

    for (int i = 0; i < 24; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      r = model(ra, rb, rc, rs);
      run_op($sformatf("rand%0d", i), ra, rb, rc, rs, r[WIDTH-1:0], r[WIDTH]);
      if ($urandom_range(1, 0) == 1) tick();
    end
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
